// File: rtl/d16_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : d16_alu_seq
//  Description : Sequencing front-end for the combinational d16_alu. Accepts
//                one command per valid/ready handshake and drives the ALU.
//                Captures the result and flags, then returns them through a
//                second valid/ready handshake. Adds a 16-step shift-and-add
//                unsigned multiply that reuses the ALU ADD path.
//  Revision    : 1.0 - initial release
// ============================================================================
module d16_alu_seq #(
    parameter int WIDTH     = 16,
    parameter int MUL_STEPS = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    // command handshake
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    // result handshake
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_s,
    output logic [WIDTH-1:0] res_hi,
    output logic             res_n,
    output logic             res_o,
    output logic             res_z,
    output logic             res_c,
    // combinational ALU interface
    output logic [2:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_s,
    input  logic             alu_n,
    input  logic             alu_o,
    input  logic             alu_z,
    input  logic             alu_c,
    output logic             busy
);

    localparam int                 c_CNT_W    = $clog2(MUL_STEPS);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MUL_STEPS - 1);
    localparam logic [2:0]         c_OP_NOP   = 3'b000;
    localparam logic [2:0]         c_OP_ADD   = 3'b001;
    localparam logic [2:0]         c_OP_MUL   = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    // r_opa doubles as the multiplicand, r_opb as the multiplier / low
    // accumulator; neither role overlaps with the single-cycle EXEC use.
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_hi;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_accept;
    logic               w_reserved;
    logic               w_mul_last;
    logic [WIDTH-1:0]   w_hi_next;
    logic [WIDTH-1:0]   w_lo_next;

    assign w_accept   = cmd_valid & cmd_ready;
    assign w_reserved = r_op[2] & r_op[1];
    assign w_mul_last = (r_cnt == c_CNT_LAST);
    // One multiply step: the 17-bit sum shifts right into {hi, lo}.
    assign w_hi_next  = {alu_c, alu_s[WIDTH-1:1]};
    assign w_lo_next  = {alu_s[0], r_opb[WIDTH-1:1]};

    // State register
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, handshake and ALU drive decode
    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        res_valid    = 1'b0;
        busy         = 1'b1;
        alu_ctrl     = c_OP_NOP;
        alu_a        = '0;
        alu_b        = '0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    w_state_next = (cmd_op == c_OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: begin
                if (!w_reserved) begin
                    alu_ctrl = r_op;
                    alu_a    = r_opa;
                    alu_b    = r_opb;
                end
                w_state_next = S_DONE;
            end
            S_MUL: begin
                alu_ctrl = c_OP_ADD;
                alu_a    = r_hi;
                alu_b    = r_opb[0] ? r_opa : '0;
                if (w_mul_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand latch, multiply accumulators and result capture
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_op   <= c_OP_NOP;
            r_opa  <= '0;
            r_opb  <= '0;
            r_hi   <= '0;
            r_cnt  <= '0;
            res_s  <= '0;
            res_hi <= '0;
            res_n  <= 1'b0;
            res_o  <= 1'b0;
            res_z  <= 1'b0;
            res_c  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= cmd_op;
                        r_opa <= cmd_a;
                        r_opb <= cmd_b;
                        r_hi  <= '0;
                        r_cnt <= '0;
                    end
                end
                S_EXEC: begin
                    res_hi <= '0;
                    if (w_reserved) begin
                        res_s <= '0;
                        res_n <= 1'b0;
                        res_o <= 1'b0;
                        res_z <= 1'b0;
                        res_c <= 1'b0;
                    end else begin
                        res_s <= alu_s;
                        res_n <= alu_n;
                        res_o <= alu_o;
                        res_z <= alu_z;
                        res_c <= alu_c;
                    end
                end
                S_MUL: begin
                    r_hi  <= w_hi_next;
                    r_opb <= w_lo_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_mul_last) begin
                        res_s  <= w_lo_next;
                        res_hi <= w_hi_next;
                        res_n  <= w_hi_next[WIDTH-1];
                        res_z  <= ~|{w_hi_next, w_lo_next};
                        res_o  <= |w_hi_next;
                        res_c  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/d16_alu_seq.md
Name: d16_alu_seq

Overview:
Sequencing front-end that sits between the d16 decode/issue logic and the combinational d16_alu. It accepts one ALU command per valid/ready handshake and drives the ALU operands and control. It captures the result and N/O/Z/C flags into registers and returns them through a second valid/ready handshake. It adds a multi-cycle 16x16->32 unsigned multiply (MUL), built by iterating the ALU ADD operation 16 times.

Parameters:
WIDTH, 16, datapath width; fixed at 16 for d16, present for bench readability only.
MUL_STEPS, 16, multiply iterations; must equal WIDTH.

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst_n  in  1  synchronous reset, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_op  in  3  000 NOP, 001 ADD, 010 SUB, 011 LSH, 100 RSH, 101 MUL, 110/111 reserved
cmd_a  in  16  operand A
cmd_b  in  16  operand B
res_valid  out  1  result registers hold a valid result
res_ready  in  1  consumer takes the result
res_s  out  16  result, or product low half
res_hi  out  16  product high half; 0 for non-MUL ops
res_n, res_o, res_z, res_c  out  1 each  captured flags
alu_ctrl  out  3  to d16_alu ctrl_alu
alu_a, alu_b  out  16 each  to d16_alu a, b
alu_s  in  16  from d16_alu s
alu_n, alu_o, alu_z, alu_c  in  1 each  from d16_alu flags
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (sys_rst_n low at a clock edge):
  - state=IDLE; all res_* = 0; res_valid=0; alu_ctrl=000; alu_a=alu_b=0; internal counter and accumulators = 0.
  - Reset asserted mid-operation aborts that operation. No result is produced.
- States: IDLE, EXEC, MUL, DONE.
- IDLE:
  - cmd_ready=1; alu_ctrl=000.
  - Accept occurs at an edge with cmd_valid&cmd_ready: latch op, a, b.
  - Next state: MUL if op=101, else EXEC.
- EXEC (exactly 1 cycle):
  - alu_ctrl=latched op; alu_a/alu_b=latched operands.
  - At the next edge: res_s<=alu_s, res_n/o/z/c<=alu flags, res_hi<=0; go to DONE.
  - Reserved ops (110/111): alu_ctrl=000; res_s=0, flags=0, res_hi=0.
  - Latency: accept at edge k, res_valid=1 after edge k+1.
- MUL:
  - On accept: hi_acc<=0, lo_acc<=cmd_b, mcand<=cmd_a, cnt<=0.
  - Each MUL cycle: alu_ctrl=001, alu_a=hi_acc, alu_b=(lo_acc[0] ? mcand : 0).
  - At the edge:
    - hi_acc<={alu_c, alu_s[15:1]}
    - lo_acc<={alu_s[0], lo_acc[15:1]}
    - cnt<=cnt+1
  - After the step with cnt=15, capture:
    - res_s=final lo_acc, res_hi=final hi_acc
    - res_n=product bit 31
    - res_z=(product==0)
    - res_o=(res_hi!=0), i.e. result does not fit in 16 bits
    - res_c=0
  - Then go to DONE. Latency: accept at edge k, res_valid=1 after edge k+16.
- DONE:
  - res_valid=1; cmd_ready=0; alu_ctrl=000.
  - res_* are stable while res_valid=1 and res_ready=0.
  - At an edge with res_ready=1: res_valid<=0, go to IDLE. res_* keep their last value until overwritten.
- No command overlap: cmd_ready=0 in EXEC/MUL/DONE. cmd_valid in those states is ignored, not queued.
- cmd_* inputs may change freely after accept; only latched copies are used.
- NOP returns alu_s for ctrl 000 with its flags, with 1-cycle latency like EXEC.

Test Plan:
- ADD: cmd_op=001, a=0x0001, b=0x0001, res_ready=1 -> res_valid 1 cycle after accept; res_s=0x0002, res_hi=0, z=0, c=0; cmd_ready back to 1 one cycle later.
- SUB then LSH/RSH back-to-back: SUB 0x0001-0x0001 -> res_s=0x0000, z=1. LSH 1,1 and RSH 1,1 -> res_s and flags match the d16_alu outputs for the same ctrl/a/b.
- MUL: a=0x1234, b=0x0010 -> res_valid exactly 16 cycles after accept; res_s=0x2340, res_hi=0x0001, o=1, z=0.
- MUL edge cases:
  - 0xFFFF*0xFFFF -> res_s=0x0001, res_hi=0xFFFE, n=1, o=1.
  - 0x0000*0xABCD -> all zero, z=1, o=0.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid -> res_* unchanged, cmd_ready=0; an offered cmd_valid is not accepted; accept occurs only after res_ready=1.
- Reset mid-MUL: drop sys_rst_n at MUL step 8 for 1 cycle -> all outputs 0 next cycle; no res_valid; a new ADD 2+3 then completes with res_s=0x0005.
